mips_cpu: RTL and testbench

Single-cycle MIPS-subset processor core with a minimal coprocessor 0 (SR, Cause, EPC) and one external interrupt line. It sits at the top of the CPU tile and connects directly to:
- an instruction ROM (combinational read);
- a data RAM (combinational read, byte-enabled synchronous write);
- a memory-mapped interrupt-acknowledge port at 0x7F20.

Every committed register write and store is exposed on trace ports for the system bench.

---
 rtl/mips_cpu_pkg.sv | 65 ++++++
 rtl/mips_cpu_cp0.sv | 102 ++++++++++
 rtl/mips_cpu.sv | 261 ++++++++++++++++++++++++++
 tb/tb_mips_cpu.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/mips_cpu_pkg.sv
// mips_cpu_pkg: shared definitions for the mips_cpu core.
// Contents: opcode/funct/COP0 field constants, CP0 register numbers,
// exception codes, default address parameters, decode enums and a
// sign-extension helper.
package mips_cpu_pkg;

    localparam logic [31:0] DEF_RESET_PC     = 32'h0000_3000;
    localparam logic [31:0] DEF_HANDLER_PC   = 32'h0000_4180;
    localparam logic [31:0] DEF_INT_ACK_ADDR = 32'h0000_7F20;

    // Primary opcodes
    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_LUI   = 6'h0F;
    localparam logic [5:0] OP_COP0  = 6'h10;
    localparam logic [5:0] OP_LB    = 6'h20;
    localparam logic [5:0] OP_LH    = 6'h21;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SB    = 6'h28;
    localparam logic [5:0] OP_SH    = 6'h29;
    localparam logic [5:0] OP_SW    = 6'h2B;

    // R-type funct codes (FN_ERET is the funct of the COP0 eret form)
    localparam logic [5:0] FN_SLL  = 6'h00;
    localparam logic [5:0] FN_JR   = 6'h08;
    localparam logic [5:0] FN_ERET = 6'h18;
    localparam logic [5:0] FN_ADD  = 6'h20;
    localparam logic [5:0] FN_SUB  = 6'h22;
    localparam logic [5:0] FN_AND  = 6'h24;
    localparam logic [5:0] FN_OR   = 6'h25;
    localparam logic [5:0] FN_SLT  = 6'h2A;
    localparam logic [5:0] FN_SLTU = 6'h2B;

    // COP0 rs-field sub-opcodes
    localparam logic [4:0] COP0_MF = 5'h00;
    localparam logic [4:0] COP0_MT = 5'h04;

    // CP0 register numbers
    localparam logic [4:0] CP0_SR    = 5'd12;
    localparam logic [4:0] CP0_CAUSE = 5'd13;
    localparam logic [4:0] CP0_EPC   = 5'd14;

    // Cause.ExcCode values
    localparam logic [4:0] EXC_INT = 5'd0;
    localparam logic [4:0] EXC_RI  = 5'd10;

    typedef enum logic [2:0] {
        ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_SLT, ALU_SLTU, ALU_LUI
    } alu_op_e;

    typedef enum logic [1:0] {WB_ALU, WB_MEM, WB_PC4, WB_CP0} wb_sel_e;

    typedef enum logic [1:0] {SZ_W, SZ_H, SZ_B} mem_size_e;

    function automatic logic [31:0] sext16(input logic [15:0] v);
        return {{16{v[15]}}, v};
    endfunction

endpackage

// File: rtl/mips_cpu_cp0.sv
// mips_cpu_cp0: minimal coprocessor 0 (SR, Cause, EPC) and the exception
// entry decision for the mips_cpu core.
// Ports:
//   clk, reset        - clock, synchronous active-low reset
//   interrupt         - external level interrupt, HWInt[2] (IP/IM bit 12)
//   pc                - PC of the executing instruction (saved into EPC)
//   mtc0_en           - mtc0 executing this cycle
//   cp0_addr          - CP0 register number for mfc0/mtc0
//   cp0_wdata         - mtc0 write data
//   cp0_rdata         - mfc0 read data (SR/Cause/EPC, others read 0)
//   eret_en           - eret executing this cycle
//   ri_exc            - reserved-instruction exception request
//   int_req           - interrupt taken this cycle
//   exc_take          - any exception entry this cycle (instruction suppressed)
//   epc               - current EPC value (eret target)
module mips_cpu_cp0
    import mips_cpu_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        interrupt,
    input  logic [31:0] pc,
    input  logic        mtc0_en,
    input  logic [4:0]  cp0_addr,
    input  logic [31:0] cp0_wdata,
    output logic [31:0] cp0_rdata,
    input  logic        eret_en,
    input  logic        ri_exc,
    output logic        int_req,
    output logic        exc_take,
    output logic [31:0] epc
);

    logic [5:0]  im_q, im_d;
    logic        exl_q, exl_d;
    logic        ie_q, ie_d;
    logic [4:0]  exc_code_q, exc_code_d;
    logic [31:0] epc_q, epc_d;

    // IM[12] gates HWInt[2], which is im_q[2] since IM occupies bits 15:10.
    assign int_req  = ie_q & ~exl_q & im_q[2] & interrupt;
    // Interrupt wins over a reserved instruction: ExcCode picks EXC_INT below.
    assign exc_take = int_req | ri_exc;
    assign epc      = epc_q;

    // NOTE: every always_comb output gets a default first so no path leaves it
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        im_d       = im_q;
        exl_d      = exl_q;
        ie_d       = ie_q;
        exc_code_d = exc_code_q;
        epc_d      = epc_q;
        if (exc_take) begin
            epc_d      = pc;
            exc_code_d = int_req ? EXC_INT : EXC_RI;
            exl_d      = 1'b1;
        end else if (eret_en) begin
            exl_d = 1'b0;
        end else if (mtc0_en) begin
            case (cp0_addr)
                CP0_SR: begin
                    im_d  = cp0_wdata[15:10];
                    exl_d = cp0_wdata[1];
                    ie_d  = cp0_wdata[0];
                end
                CP0_EPC: epc_d = cp0_wdata;
                default: ;
            endcase
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (!reset) begin
            im_q       <= '0;
            exl_q      <= 1'b0;
            ie_q       <= 1'b0;
            exc_code_q <= '0;
            epc_q      <= '0;
        end else begin
            im_q       <= im_d;
            exl_q      <= exl_d;
            ie_q       <= ie_d;
            exc_code_q <= exc_code_d;
            epc_q      <= epc_d;
        end
    end

    // Cause.IP is the live interrupt line, not a stored copy.
    always_comb begin
        cp0_rdata = '0;
        case (cp0_addr)
            CP0_SR:    cp0_rdata = {16'b0, im_q, 8'b0, exl_q, ie_q};
            CP0_CAUSE: cp0_rdata = {16'b0, 3'b0, interrupt, 2'b0, 3'b0, exc_code_q, 2'b0};
            CP0_EPC:   cp0_rdata = epc_q;
            default:   cp0_rdata = '0;
        endcase
    end

endmodule

// File: rtl/mips_cpu.sv
// mips_cpu: single-cycle MIPS-subset core with minimal CP0 and one external
// interrupt. Decode, ALU, register file and load/store lane handling live
// here; CP0 state and the exception decision live in mips_cpu_cp0.
// Configuration: define MIPS_CPU_RI_EXC_EN to raise a reserved-instruction
// exception on undefined encodings; otherwise they execute as nop.
// Ports:
//   clk, reset          - clock, synchronous active-low reset
//   interrupt           - external level interrupt (HWInt[2])
//   macroscopic_pc      - PC of the executing instruction
//   i_inst_addr/rdata   - instruction ROM fetch address / word
//   m_data_addr/rdata   - data byte address / aligned read word
//   m_data_wdata/byteen - lane-replicated store data / data RAM byte enables
//   m_int_addr/byteen   - interrupt-acknowledge port address / byte enables
//   m_inst_addr         - PC of the instruction issuing the store
//   w_grf_we/addr/wdata - committed register-write trace
//   w_inst_addr         - PC of the writing instruction
module mips_cpu
    import mips_cpu_pkg::*;
#(
    parameter logic [31:0] RESET_PC     = DEF_RESET_PC,
    parameter logic [31:0] HANDLER_PC   = DEF_HANDLER_PC,
    parameter logic [31:0] INT_ACK_ADDR = DEF_INT_ACK_ADDR
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        interrupt,
    output logic [31:0] macroscopic_pc,
    output logic [31:0] i_inst_addr,
    input  logic [31:0] i_inst_rdata,
    output logic [31:0] m_data_addr,
    input  logic [31:0] m_data_rdata,
    output logic [31:0] m_data_wdata,
    output logic [3:0]  m_data_byteen,
    output logic [31:0] m_int_addr,
    output logic [3:0]  m_int_byteen,
    output logic [31:0] m_inst_addr,
    output logic        w_grf_we,
    output logic [4:0]  w_grf_addr,
    output logic [31:0] w_grf_wdata,
    output logic [31:0] w_inst_addr
);

    logic [31:0] pc_q, pc_d;
    logic [31:0] grf_q [32];

    logic [5:0]  opcode, funct;
    logic [4:0]  rs, rt, rd;
    logic [15:0] imm;
    logic [31:0] rs_data, rt_data, imm_ext, alu_b, alu_res, pc_plus4;
    logic [31:0] load_data, cp0_rdata, epc;
    logic [3:0]  byteen_raw;
    logic        int_req, exc_take, ri_exc, commit, int_hit;
    logic        unused_bits;

    // Decoded control
    logic        inst_valid, gpr_we, use_imm, imm_zext, is_store;
    logic        is_beq, is_bne, is_jump, is_jr, is_mtc0, is_eret;
    logic [4:0]  gpr_dst;
    wb_sel_e     wb_sel;
    alu_op_e     alu_op;
    mem_size_e   mem_size;

    assign opcode      = i_inst_rdata[31:26];
    assign rs          = i_inst_rdata[25:21];
    assign rt          = i_inst_rdata[20:16];
    assign rd          = i_inst_rdata[15:11];
    assign imm         = i_inst_rdata[15:0];
    assign funct       = i_inst_rdata[5:0];
    assign unused_bits = ^i_inst_rdata[10:6];

    assign i_inst_addr    = pc_q;
    assign macroscopic_pc = pc_q;
    assign m_inst_addr    = pc_q;
    assign w_inst_addr    = pc_q;

    // $0 is cleared at reset and never written, so it always reads zero.
    assign rs_data  = grf_q[rs];
    assign rt_data  = grf_q[rt];
    assign pc_plus4 = pc_q + 32'd4;

    always_comb begin
        inst_valid = 1'b1;
        gpr_we     = 1'b0;
        gpr_dst    = rd;
        wb_sel     = WB_ALU;
        alu_op     = ALU_ADD;
        use_imm    = 1'b0;
        imm_zext   = 1'b0;
        is_store   = 1'b0;
        mem_size   = SZ_W;
        is_beq     = 1'b0;
        is_bne     = 1'b0;
        is_jump    = 1'b0;
        is_jr      = 1'b0;
        is_mtc0    = 1'b0;
        is_eret    = 1'b0;
        case (opcode)
            OP_RTYPE: begin
                case (funct)
                    FN_SLL:  inst_valid = (rd == 5'd0);  // only the nop form
                    FN_JR:   is_jr = 1'b1;
                    FN_ADD:  begin gpr_we = 1'b1; alu_op = ALU_ADD;  end
                    FN_SUB:  begin gpr_we = 1'b1; alu_op = ALU_SUB;  end
                    FN_AND:  begin gpr_we = 1'b1; alu_op = ALU_AND;  end
                    FN_OR:   begin gpr_we = 1'b1; alu_op = ALU_OR;   end
                    FN_SLT:  begin gpr_we = 1'b1; alu_op = ALU_SLT;  end
                    FN_SLTU: begin gpr_we = 1'b1; alu_op = ALU_SLTU; end
                    default: inst_valid = 1'b0;
                endcase
            end
            OP_J:    is_jump = 1'b1;
            OP_JAL:  begin is_jump = 1'b1; gpr_we = 1'b1; gpr_dst = 5'd31; wb_sel = WB_PC4; end
            OP_BEQ:  is_beq = 1'b1;
            OP_BNE:  is_bne = 1'b1;
            OP_ADDI: begin gpr_we = 1'b1; gpr_dst = rt; use_imm = 1'b1; end
            OP_ANDI: begin gpr_we = 1'b1; gpr_dst = rt; use_imm = 1'b1; imm_zext = 1'b1; alu_op = ALU_AND; end
            OP_ORI:  begin gpr_we = 1'b1; gpr_dst = rt; use_imm = 1'b1; imm_zext = 1'b1; alu_op = ALU_OR;  end
            OP_LUI:  begin gpr_we = 1'b1; gpr_dst = rt; alu_op = ALU_LUI; end
            OP_LW:   begin gpr_we = 1'b1; gpr_dst = rt; wb_sel = WB_MEM; mem_size = SZ_W; end
            OP_LH:   begin gpr_we = 1'b1; gpr_dst = rt; wb_sel = WB_MEM; mem_size = SZ_H; end
            OP_LB:   begin gpr_we = 1'b1; gpr_dst = rt; wb_sel = WB_MEM; mem_size = SZ_B; end
            OP_SW:   begin is_store = 1'b1; mem_size = SZ_W; end
            OP_SH:   begin is_store = 1'b1; mem_size = SZ_H; end
            OP_SB:   begin is_store = 1'b1; mem_size = SZ_B; end
            OP_COP0: begin
                if (rs == COP0_MF) begin
                    gpr_we  = 1'b1;
                    gpr_dst = rt;
                    wb_sel  = WB_CP0;
                end else if (rs == COP0_MT) begin
                    is_mtc0 = 1'b1;
                end else if (i_inst_rdata[25] && funct == FN_ERET) begin
                    is_eret = 1'b1;
                end else begin
                    inst_valid = 1'b0;
                end
            end
            default: inst_valid = 1'b0;
        endcase
    end

`ifdef MIPS_CPU_RI_EXC_EN
    assign ri_exc = ~inst_valid;
`else
    // Undefined encodings decode to no side effects, i.e. a nop.
    assign ri_exc = 1'b0 & inst_valid;
`endif

    // ALU
    assign imm_ext = imm_zext ? {16'b0, imm} : sext16(imm);
    assign alu_b   = use_imm ? imm_ext : rt_data;

    always_comb begin
        alu_res = '0;
        case (alu_op)
            ALU_ADD:  alu_res = rs_data + alu_b;
            ALU_SUB:  alu_res = rs_data - alu_b;
            ALU_AND:  alu_res = rs_data & alu_b;
            ALU_OR:   alu_res = rs_data | alu_b;
            ALU_SLT:  alu_res = {31'b0, $signed(rs_data) < $signed(alu_b)};
            ALU_SLTU: alu_res = {31'b0, rs_data < alu_b};
            ALU_LUI:  alu_res = {imm, 16'b0};
            default:  alu_res = '0;
        endcase
    end

    // Load/store lane handling; the low address bits only select lanes.
    assign m_data_addr = rs_data + sext16(imm);
    assign m_int_addr  = m_data_addr;
    assign int_hit     = (m_data_addr[31:2] == INT_ACK_ADDR[31:2]);

    always_comb begin
        load_data    = m_data_rdata;
        byteen_raw   = 4'b1111;
        m_data_wdata = rt_data;
        case (mem_size)
            SZ_H: begin
                load_data    = m_data_addr[1] ? sext16(m_data_rdata[31:16]) : sext16(m_data_rdata[15:0]);
                byteen_raw   = m_data_addr[1] ? 4'b1100 : 4'b0011;
                m_data_wdata = {2{rt_data[15:0]}};
            end
            SZ_B: begin
                case (m_data_addr[1:0])
                    2'd0:    load_data = {{24{m_data_rdata[7]}},  m_data_rdata[7:0]};
                    2'd1:    load_data = {{24{m_data_rdata[15]}}, m_data_rdata[15:8]};
                    2'd2:    load_data = {{24{m_data_rdata[23]}}, m_data_rdata[23:16]};
                    default: load_data = {{24{m_data_rdata[31]}}, m_data_rdata[31:24]};
                endcase
                byteen_raw   = 4'b0001 << m_data_addr[1:0];
                m_data_wdata = {4{rt_data[7:0]}};
            end
            default: ;
        endcase
    end

    // An exception or reset suppresses every architectural side effect.
    assign commit        = reset & ~exc_take;
    assign m_data_byteen = (commit && is_store && !int_hit) ? byteen_raw : 4'b0000;
    assign m_int_byteen  = (commit && is_store &&  int_hit) ? byteen_raw : 4'b0000;

    assign w_grf_we   = commit & gpr_we;
    assign w_grf_addr = gpr_dst;

    always_comb begin
        w_grf_wdata = alu_res;
        case (wb_sel)
            WB_MEM:  w_grf_wdata = load_data;
            WB_PC4:  w_grf_wdata = pc_plus4;
            WB_CP0:  w_grf_wdata = cp0_rdata;
            default: w_grf_wdata = alu_res;
        endcase
    end

    mips_cpu_cp0 u_cp0 (
        .clk       (clk),
        .reset     (reset),
        .interrupt (interrupt),
        .pc        (pc_q),
        .mtc0_en   (is_mtc0),
        .cp0_addr  (rd),
        .cp0_wdata (rt_data),
        .cp0_rdata (cp0_rdata),
        .eret_en   (is_eret),
        .ri_exc    (ri_exc),
        .int_req   (int_req),
        .exc_take  (exc_take),
        .epc       (epc)
    );

    // Next PC: exception entry first, then eret, then control flow.
    always_comb begin
        pc_d = pc_plus4;
        if (exc_take) begin
            pc_d = HANDLER_PC;
        end else if (is_eret) begin
            pc_d = epc;
        end else if (is_jr) begin
            pc_d = rs_data;
        end else if (is_jump) begin
            pc_d = {pc_plus4[31:28], i_inst_rdata[25:0], 2'b00};
        end else if ((is_beq && rs_data == rt_data) || (is_bne && rs_data != rt_data)) begin
            pc_d = pc_plus4 + {imm_ext[29:0], 2'b00};
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) pc_q <= RESET_PC;
        else        pc_q <= pc_d;
    end

    // NOTE: the register file is small enough to clear in reset, which makes
    // reads well defined immediately after reset release.
    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int i = 0; i < 32; i++) grf_q[i] <= '0;
        end else if (w_grf_we && w_grf_addr != 5'd0) begin
            grf_q[w_grf_addr] <= w_grf_wdata;
        end
    end

endmodule

// File: tb/tb_mips_cpu.sv
// tb_mips_cpu: directed, table-driven bench for mips_cpu. A program in the
// instruction ROM model is stepped one cycle per table row and the trace
// ports are compared against hand-computed values.
module tb_mips_cpu;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        interrupt = 1'b0;
    logic [31:0] macroscopic_pc, i_inst_addr, i_inst_rdata;
    logic [31:0] m_data_addr, m_data_rdata, m_data_wdata, m_int_addr, m_inst_addr;
    logic [3:0]  m_data_byteen, m_int_byteen;
    logic        w_grf_we;
    logic [4:0]  w_grf_addr;
    logic [31:0] w_grf_wdata, w_inst_addr;

    mips_cpu dut (
        .clk            (clk),
        .reset          (reset),
        .interrupt      (interrupt),
        .macroscopic_pc (macroscopic_pc),
        .i_inst_addr    (i_inst_addr),
        .i_inst_rdata   (i_inst_rdata),
        .m_data_addr    (m_data_addr),
        .m_data_rdata   (m_data_rdata),
        .m_data_wdata   (m_data_wdata),
        .m_data_byteen  (m_data_byteen),
        .m_int_addr     (m_int_addr),
        .m_int_byteen   (m_int_byteen),
        .m_inst_addr    (m_inst_addr),
        .w_grf_we       (w_grf_we),
        .w_grf_addr     (w_grf_addr),
        .w_grf_wdata    (w_grf_wdata),
        .w_inst_addr    (w_inst_addr)
    );

    always #5 clk = ~clk;

    // Memory models: main program at 0x3000, handler at 0x4180, 256 B of data.
    logic [31:0] imem [64];
    logic [31:0] hmem [16];
    logic [31:0] dmem [64];
    int          ack_cnt = 0;

    always_comb begin
        i_inst_rdata = 32'h0;
        if (i_inst_addr >= 32'h3000 && i_inst_addr < 32'h3100)
            i_inst_rdata = imem[i_inst_addr[7:2]];
        else if (i_inst_addr >= 32'h4180 && i_inst_addr < 32'h41C0)
            i_inst_rdata = hmem[i_inst_addr[5:2]];
    end

    assign m_data_rdata = dmem[m_data_addr[7:2]];

    always @(posedge clk) begin
        for (int b = 0; b < 4; b++)
            if (m_data_byteen[b]) dmem[m_data_addr[7:2]][8*b +: 8] <= m_data_wdata[8*b +: 8];
        if (|m_int_byteen) ack_cnt <= ack_cnt + 1;
    end

    typedef struct {
        logic        irq;
        logic [31:0] pc;
        logic        we;
        logic [4:0]  waddr;
        logic [31:0] wdata;
        logic [3:0]  dbe;
        logic [3:0]  ibe;
        logic [31:0] maddr;
        logic [31:0] mwdata;
    } vec_t;

    localparam int NV = 32;
    vec_t vecs [NV];
    int   tests = 0;
    int   fails = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic irq, input logic [31:0] pc, input logic we,
                                input logic [4:0] wa, input logic [31:0] wd,
                                input logic [3:0] dbe, input logic [3:0] ibe,
                                input logic [31:0] maddr, input logic [31:0] mwd);
        vec_t v;
        v.irq = irq; v.pc = pc; v.we = we; v.waddr = wa; v.wdata = wd;
        v.dbe = dbe; v.ibe = ibe; v.maddr = maddr; v.mwdata = mwd;
        return v;
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 64; i++) begin imem[i] = 32'h0; dmem[i] = 32'h0; end
        for (int i = 0; i < 16; i++) hmem[i] = 32'h0;
        dmem[1] = 32'h0000_8000;

        imem[6'h00] = 32'h34011234;  // 3000 ori  $1,$0,0x1234
        imem[6'h01] = 32'hA0010001;  // 3004 sb   $1,1($0)
        imem[6'h02] = 32'h80020005;  // 3008 lb   $2,5($0)
        imem[6'h03] = 32'h34031001;  // 300C ori  $3,$0,0x1001
        imem[6'h04] = 32'h40836000;  // 3010 mtc0 $3,$12
        imem[6'h05] = 32'h00222020;  // 3014 add  $4,$1,$2
        imem[6'h06] = 32'h00414022;  // 3018 sub  $8,$2,$1
        imem[6'h07] = 32'h0041482A;  // 301C slt  $9,$2,$1
        imem[6'h08] = 32'h0041502B;  // 3020 sltu $10,$2,$1
        imem[6'h09] = 32'h3C0B8000;  // 3024 lui  $11,0x8000
        imem[6'h0A] = 32'h216CFFFF;  // 3028 addi $12,$11,-1
        imem[6'h0B] = 32'h304DFF80;  // 302C andi $13,$2,0xFF80
        imem[6'h0C] = 32'hA4020002;  // 3030 sh   $2,2($0)
        imem[6'h0D] = 32'h840E0002;  // 3034 lh   $14,2($0)
        imem[6'h0E] = 32'h840F0000;  // 3038 lh   $15,0($0)
        imem[6'h0F] = 32'h8C100000;  // 303C lw   $16,0($0)
        imem[6'h10] = 32'h10210002;  // 3040 beq  $1,$1,+2
        imem[6'h11] = 32'h3414DEAD;  // 3044 skipped
        imem[6'h12] = 32'h3414DEAD;  // 3048 skipped
        imem[6'h13] = 32'h14210005;  // 304C bne  $1,$1,+5 (not taken)
        imem[6'h14] = 32'h0C000C1C;  // 3050 jal  0x3070
        imem[6'h15] = 32'hFC000000;  // 3054 undefined opcode
        imem[6'h16] = 32'h00210020;  // 3058 add  $0,$1,$1
        imem[6'h17] = 32'h00019025;  // 305C or   $18,$0,$1
        imem[6'h18] = 32'h08000C20;  // 3060 j    0x3080
        imem[6'h1C] = 32'h03E00008;  // 3070 jr   $31
        imem[6'h20] = 32'h00229824;  // 3080 and  $19,$1,$2
        imem[6'h21] = 32'h40146000;  // 3084 mfc0 $20,$12
        imem[6'h22] = 32'hAC010000;  // 3088 sw   $1,0($0)
        hmem[0]     = 32'h40056800;  // 4180 mfc0 $5,$13
        hmem[1]     = 32'h40067000;  // 4184 mfc0 $6,$14
        hmem[2]     = 32'hAC017F20;  // 4188 sw   $1,0x7F20($0)
        hmem[3]     = 32'h40076000;  // 418C mfc0 $7,$12
        hmem[4]     = 32'h42000018;  // 4190 eret

        //               irq  pc          we wa  wdata         dbe      ibe      maddr         mwdata
        vecs[0]  = mk(1'b0, 32'h3000, 1, 1,  32'h00001234, 4'b0000, 4'b0000, 32'h0,       32'h0);
        vecs[1]  = mk(1'b0, 32'h3004, 0, 0,  32'h0,        4'b0010, 4'b0000, 32'h1,       32'h34343434);
        vecs[2]  = mk(1'b0, 32'h3008, 1, 2,  32'hFFFFFF80, 4'b0000, 4'b0000, 32'h0,       32'h0);
        vecs[3]  = mk(1'b0, 32'h300C, 1, 3,  32'h00001001, 4'b0000, 4'b0000, 32'h0,       32'h0);
        vecs[4]  = mk(1'b0, 32'h3010, 0, 0,  32'h0,        4'b0000, 4'b0000, 32'h0,       32'h0);
        vecs[5]  = mk(1'b1, 32'h3014, 0, 0,  32'h0,        4'b0000, 4'b0000, 32'h0,       32'h0);
        vecs[6]  = mk(1'b1, 32'h4180, 1, 5,  32'h00001000, 4'b0000, 4'b0000, 32'h0,       32'h0);
        vecs[7]  = mk(1'b1, 32'h4184, 1, 6,  32'h00003014, 4'b0000, 4'b0000, 32'h0,       32'h0);
        vecs[8]  = mk(1'b0, 32'h4188, 0, 0,  32'h0,        4'b0000, 4'b1111, 32'h00007F20, 32'h00001234);
        vecs[9]  = mk(1'b0, 32'h418C, 1, 7,  32'h00001003, 4'b0000, 4'b0000, 32'h0,       32'h0);
        vecs[10] = mk(1'b0, 32'h4190, 0, 0,  32'h0,        4'b0000, 4'b0000, 32'h0,       32'h0);
        vecs[11] = mk(1'b0, 32'h3014, 1, 4,  32'h000011B4, 4'b0000, 4'b0000, 32'h0,       32'h0);
        vecs[12] = mk(1'b0, 32'h3018, 1, 8,  32'hFFFFED4C, 4'b0000, 4'b0000, 32'h0,       32'h0);
        vecs[13] = mk(1'b0, 32'h301C, 1, 9,  32'h00000001, 4'b0000, 4'b0000, 32'h0,       32'h0);
        vecs[14] = mk(1'b0, 32'h3020, 1, 10, 32'h00000000, 4'b0000, 4'b0000, 32'h0,       32'h0);
        vecs[15] = mk(1'b0, 32'h3024, 1, 11, 32'h80000000, 4'b0000, 4'b0000, 32'h0,       32'h0);
        vecs[16] = mk(1'b0, 32'h3028, 1, 12, 32'h7FFFFFFF, 4'b0000, 4'b0000, 32'h0,       32'h0);
        vecs[17] = mk(1'b0, 32'h302C, 1, 13, 32'h0000FF80, 4'b0000, 4'b0000, 32'h0,       32'h0);
        vecs[18] = mk(1'b0, 32'h3030, 0, 0,  32'h0,        4'b1100, 4'b0000, 32'h2,       32'hFF80FF80);
        vecs[19] = mk(1'b0, 32'h3034, 1, 14, 32'hFFFFFF80, 4'b0000, 4'b0000, 32'h0,       32'h0);
        vecs[20] = mk(1'b0, 32'h3038, 1, 15, 32'h00003400, 4'b0000, 4'b0000, 32'h0,       32'h0);
        vecs[21] = mk(1'b0, 32'h303C, 1, 16, 32'hFF803400, 4'b0000, 4'b0000, 32'h0,       32'h0);
        vecs[22] = mk(1'b0, 32'h3040, 0, 0,  32'h0,        4'b0000, 4'b0000, 32'h0,       32'h0);
        vecs[23] = mk(1'b0, 32'h304C, 0, 0,  32'h0,        4'b0000, 4'b0000, 32'h0,       32'h0);
        vecs[24] = mk(1'b0, 32'h3050, 1, 31, 32'h00003054, 4'b0000, 4'b0000, 32'h0,       32'h0);
        vecs[25] = mk(1'b0, 32'h3070, 0, 0,  32'h0,        4'b0000, 4'b0000, 32'h0,       32'h0);
        vecs[26] = mk(1'b0, 32'h3054, 0, 0,  32'h0,        4'b0000, 4'b0000, 32'h0,       32'h0);
        vecs[27] = mk(1'b0, 32'h3058, 1, 0,  32'h00002468, 4'b0000, 4'b0000, 32'h0,       32'h0);
        vecs[28] = mk(1'b0, 32'h305C, 1, 18, 32'h00001234, 4'b0000, 4'b0000, 32'h0,       32'h0);
        vecs[29] = mk(1'b0, 32'h3060, 0, 0,  32'h0,        4'b0000, 4'b0000, 32'h0,       32'h0);
        vecs[30] = mk(1'b0, 32'h3080, 1, 19, 32'h00001200, 4'b0000, 4'b0000, 32'h0,       32'h0);
        vecs[31] = mk(1'b0, 32'h3084, 1, 20, 32'h00001001, 4'b0000, 4'b0000, 32'h0,       32'h0);

        // Reset held low: PC loads RESET_PC and side effects are masked.
        reset = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_pc", i_inst_addr, 32'h3000);
        check("reset_grf_we", {31'b0, w_grf_we}, 32'h0);
        check("reset_byteen", {24'b0, m_data_byteen, m_int_byteen}, 32'h0);
        reset = 1'b1;

        for (int i = 0; i < NV; i++) begin
            interrupt = vecs[i].irq;
            #1;
            check($sformatf("v%0d_pc", i), macroscopic_pc, vecs[i].pc);
            check($sformatf("v%0d_inst_addr", i), i_inst_addr, vecs[i].pc);
            check($sformatf("v%0d_w_inst_addr", i), w_inst_addr, vecs[i].pc);
            check($sformatf("v%0d_m_inst_addr", i), m_inst_addr, vecs[i].pc);
            check($sformatf("v%0d_grf_we", i), {31'b0, w_grf_we}, {31'b0, vecs[i].we});
            if (vecs[i].we) begin
                check($sformatf("v%0d_grf_addr", i), {27'b0, w_grf_addr}, {27'b0, vecs[i].waddr});
                check($sformatf("v%0d_grf_wdata", i), w_grf_wdata, vecs[i].wdata);
            end
            check($sformatf("v%0d_data_byteen", i), {28'b0, m_data_byteen}, {28'b0, vecs[i].dbe});
            check($sformatf("v%0d_int_byteen", i), {28'b0, m_int_byteen}, {28'b0, vecs[i].ibe});
            if (|vecs[i].dbe) begin
                check($sformatf("v%0d_data_addr", i), m_data_addr, vecs[i].maddr);
                check($sformatf("v%0d_data_wdata", i), m_data_wdata, vecs[i].mwdata);
            end
            if (|vecs[i].ibe) begin
                check($sformatf("v%0d_int_addr", i), m_int_addr, vecs[i].maddr);
                check($sformatf("v%0d_int_wdata", i), m_data_wdata, vecs[i].mwdata);
            end
            @(posedge clk);
            #1;
        end

        // Reset asserted mid-program on a store: the store must be masked.
        check("seq_pc_before_reset", i_inst_addr, 32'h3088);
        reset = 1'b0;
        #1;
        check("seq_reset_store_masked", {28'b0, m_data_byteen}, 32'h0);
        check("seq_reset_int_masked", {28'b0, m_int_byteen}, 32'h0);
        @(posedge clk);
        #1;
        // After release SR is clear, so a raised interrupt must not be taken.
        reset = 1'b1;
        interrupt = 1'b1;
        #1;
        check("seq_restart_pc", i_inst_addr, 32'h3000);
        check("seq_restart_we", {31'b0, w_grf_we}, 32'h1);
        check("seq_restart_wdata", w_grf_wdata, 32'h00001234);
        @(posedge clk);
        #1;
        check("seq_no_irq_pc", i_inst_addr, 32'h3004);
        check("seq_no_irq_sb", {28'b0, m_data_byteen}, 32'h2);
        interrupt = 1'b0;

        check("ack_count", ack_cnt, 32'd1);
        check("dmem0_final", dmem[0], 32'hFF803400);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
